// File: rtl/nios2_debug_ocimem_arbiter_if.sv
// nios2_debug_ocimem_arbiter_if: bus bundle between the OCI RAM arbiter, its two requesters and the RAM
// Signals:
//   jtag_*  sysclk-domain JTAG debug strobes in, MonDReg data / monitor_ready / overrun out
//   cpu_*   debug-mode Avalon slave port (read/write held until waitrequest drops)
//   ram_*   single-port OCI RAM, one-cycle read latency
// Modports: slave = arbiter side, master = requesters and RAM side.
interface nios2_debug_ocimem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  jtag_addr_load;
    logic [ADDR_W-1:0]     jtag_addr;
    logic                  jtag_rd;
    logic                  jtag_wr;
    logic [DATA_W-1:0]     jtag_wdata;
    logic [DATA_W-1:0]     jtag_rdata;
    logic                  jtag_ready;
    logic                  jtag_overrun;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [ADDR_W-1:0]     cpu_address;
    logic [DATA_W-1:0]     cpu_writedata;
    logic [DATA_W/8-1:0]   cpu_byteenable;
    logic                  cpu_waitrequest;
    logic [DATA_W-1:0]     cpu_readdata;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W/8-1:0]   ram_be;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_W-1:0]     ram_rdata;

    modport slave (
        input  jtag_addr_load, jtag_addr, jtag_rd, jtag_wr, jtag_wdata,
        output jtag_rdata, jtag_ready, jtag_overrun,
        input  cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byteenable,
        output cpu_waitrequest, cpu_readdata,
        output ram_addr, ram_wdata, ram_be, ram_we, ram_re,
        input  ram_rdata
    );

    modport master (
        output jtag_addr_load, jtag_addr, jtag_rd, jtag_wr, jtag_wdata,
        input  jtag_rdata, jtag_ready, jtag_overrun,
        output cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byteenable,
        input  cpu_waitrequest, cpu_readdata,
        input  ram_addr, ram_wdata, ram_be, ram_we, ram_re,
        output ram_rdata
    );
endinterface

// File: rtl/nios2_debug_ocimem_arbiter.sv
// nios2_debug_ocimem_arbiter: shares the single-port OCI RAM between the JTAG debug path and the CPU debug slave
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      slave view of nios2_debug_ocimem_arbiter_if (JTAG strobes, Avalon slave, RAM port)
// JTAG requests park in a one-entry pending register and access the RAM at an
// auto-incrementing pointer; CPU requests are served straight off the Avalon port.
// Reads take an extra RD_CAP cycle to capture the RAM's registered output.
module nios2_debug_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset_n,
    nios2_debug_ocimem_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0, RD_CAP = 1'b1;
    localparam logic CPU = 1'b0, JTAG = 1'b1;

    logic              state;
    logic              last_grant;
    logic              rd_jtag;
    logic              pend_v;
    logic              pend_wr;
    logic [DATA_W-1:0] pend_wdata;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              overrun;
    logic              cpu_req, idle, cap_cpu, cap_jtag, grant_j, grant_c, jtag_req, jtag_busy, jtag_take, jtag_drop;

    // Everything that touches the RAM or the Avalon handshake is gated by reset_n so
    // nothing is issued and waitrequest is held while reset is asserted.
    always_comb begin
        cpu_req   = bus.cpu_read || bus.cpu_write;
        idle      = reset_n && state == IDLE;
        cap_cpu   = reset_n && state == RD_CAP && !rd_jtag;
        cap_jtag  = reset_n && state == RD_CAP && rd_jtag;
        grant_j   = idle && pend_v && (!cpu_req || last_grant == CPU);
        grant_c   = idle && cpu_req && !grant_j;
        jtag_req  = bus.jtag_rd || bus.jtag_wr;
        jtag_busy = pend_v || cap_jtag;
        jtag_take = jtag_req && !jtag_busy;
        jtag_drop = (jtag_req && jtag_busy) || (bus.jtag_rd && bus.jtag_wr);
    end

    assign bus.ram_we          = grant_j ? pend_wr : grant_c && bus.cpu_write;
    assign bus.ram_re          = grant_j ? !pend_wr : grant_c && !bus.cpu_write;
    assign bus.ram_addr        = grant_j ? ptr : grant_c ? bus.cpu_address : '0;
    assign bus.ram_wdata       = grant_j ? pend_wdata : grant_c ? bus.cpu_writedata : '0;
    assign bus.ram_be          = grant_j ? '1 : grant_c ? bus.cpu_byteenable : '0;
    assign bus.cpu_readdata    = cap_cpu ? bus.ram_rdata : '0;
    assign bus.cpu_waitrequest = !reset_n || (cpu_req && !(cap_cpu || (grant_c && bus.cpu_write)));
    assign bus.jtag_rdata      = rdata;
    assign bus.jtag_ready      = ready;
    assign bus.jtag_overrun    = overrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= CPU;
            rd_jtag    <= 1'b0;
            pend_v     <= 1'b0;
            pend_wr    <= 1'b0;
            pend_wdata <= '0;
            ptr        <= '0;
            rdata      <= '0;
            ready      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= bus.ram_re ? RD_CAP : IDLE;
            if (bus.ram_re) rd_jtag <= grant_j;
            // Only a contested grant moves the round-robin pointer, so the side that
            // lost a tie is guaranteed to win the next one.
            if (idle && pend_v && cpu_req) last_grant <= grant_j ? JTAG : CPU;
            pend_v <= jtag_take || (pend_v && !grant_j);
            if (jtag_take) begin
                pend_wr    <= bus.jtag_wr;
                pend_wdata <= bus.jtag_wdata;
            end
            ptr     <= bus.jtag_addr_load ? bus.jtag_addr : grant_j ? ptr + 1'b1 : ptr;
            overrun <= !bus.jtag_addr_load && (overrun || jtag_drop);
            ready   <= (grant_j && pend_wr) || cap_jtag;
            if (cap_jtag) rdata <= bus.ram_rdata;
        end
    end
endmodule
